// File: rtl/ahb_apb_bridge.sv
// AHB-Lite to APB bridge.
// Every AHB word transfer becomes one APB SETUP/ACCESS pair. A write spends
// one extra cycle (WLATCH) waiting for HWDATA in the AHB data phase. APB
// errors and ACCESS timeouts are returned as a two-cycle AHB ERROR response.
// HREADYOUT, HRESP and HRDATA are decoded from the state register and the
// live APB response, so a completing ACCESS cycle is visible to AHB in the
// same cycle.
module ahb_apb_bridge #(
  parameter int TIMEOUT = 255
) (
  input  logic        HCLK,
  input  logic        HRESETn,
  input  logic        HSEL,
  input  logic [31:0] HADDR,
  input  logic [1:0]  HTRANS,
  input  logic        HWRITE,
  input  logic [2:0]  HSIZE,
  input  logic [31:0] HWDATA,
  input  logic        HREADY,
  output logic        HREADYOUT,
  output logic        HRESP,
  output logic [31:0] HRDATA,
  output logic [31:0] PADDR,
  output logic        PSEL,
  output logic        PENABLE,
  output logic        PWRITE,
  output logic [31:0] PWDATA,
  input  logic [31:0] PRDATA,
  input  logic        PREADY,
  input  logic        PSLVERR
);

  // The counter only has to reach TIMEOUT-1.
  localparam int CNT_W = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'((TIMEOUT > 0) ? (TIMEOUT - 1) : 0);

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_WLATCH = 3'd1,
    ST_SETUP  = 3'd2,
    ST_ACCESS = 3'd3,
    ST_ERR1   = 3'd4,
    ST_ERR2   = 3'd5
  } state_t;

  state_t           state_r;
  state_t           state_s;
  logic [CNT_W-1:0] cnt_r;
  logic             acc_ok_s;
  logic             acc_err_s;
  logic             timeout_s;
  logic             accept_s;

  // All transfers are words, so the size field carries no information.
  logic             unused_hsize_s;
  assign unused_hsize_s = ^HSIZE;

  // Classify the current cycle: ACCESS outcome and AHB acceptance.
  always_comb begin
    acc_ok_s  = 1'b0;
    acc_err_s = 1'b0;
    timeout_s = 1'b0;
    accept_s  = 1'b0;
    if (state_r == ST_ACCESS) begin
      acc_ok_s  = PREADY & ~PSLVERR;
      acc_err_s = PREADY & PSLVERR;
      timeout_s = (TIMEOUT > 0) && !PREADY && (cnt_r == CNT_LAST);
    end else begin
      acc_ok_s  = 1'b0;
    end
    // New transfers are only taken where the bridge is ready for them:
    // idle, end of an error response, or a clean ACCESS completion.
    if ((state_r == ST_IDLE) || (state_r == ST_ERR2) || acc_ok_s) begin
      accept_s = HSEL & HREADY & HTRANS[1];
    end else begin
      accept_s = 1'b0;
    end
  end

  // Next-state logic.
  always_comb begin
    state_s = state_r;
    case (state_r)
      ST_IDLE, ST_ERR2: begin
        if (accept_s) begin
          state_s = HWRITE ? ST_WLATCH : ST_SETUP;
        end else begin
          state_s = ST_IDLE;
        end
      end
      ST_WLATCH: state_s = ST_SETUP;
      ST_SETUP:  state_s = ST_ACCESS;
      ST_ACCESS: begin
        if (acc_err_s || timeout_s) begin
          state_s = ST_ERR1;
        end else if (acc_ok_s) begin
          if (accept_s) begin
            state_s = HWRITE ? ST_WLATCH : ST_SETUP;
          end else begin
            state_s = ST_IDLE;
          end
        end else begin
          state_s = ST_ACCESS;
        end
      end
      ST_ERR1:  state_s = ST_ERR2;
      default:  state_s = ST_IDLE;
    endcase
  end

  // AHB response and APB strobes decoded from the state.
  always_comb begin
    HREADYOUT = 1'b1;
    HRESP     = 1'b0;
    HRDATA    = 32'h0000_0000;
    PSEL      = 1'b0;
    PENABLE   = 1'b0;
    case (state_r)
      ST_IDLE: begin
        HREADYOUT = 1'b1;
      end
      ST_WLATCH: begin
        HREADYOUT = 1'b0;
      end
      ST_SETUP: begin
        HREADYOUT = 1'b0;
        PSEL      = 1'b1;
      end
      ST_ACCESS: begin
        PSEL      = 1'b1;
        PENABLE   = 1'b1;
        HREADYOUT = acc_ok_s;
        // Read data is forwarded only on a clean read completion.
        if (acc_ok_s && !PWRITE) begin
          HRDATA = PRDATA;
        end else begin
          HRDATA = 32'h0000_0000;
        end
      end
      ST_ERR1: begin
        HREADYOUT = 1'b0;
        HRESP     = 1'b1;
      end
      ST_ERR2: begin
        HREADYOUT = 1'b1;
        HRESP     = 1'b1;
      end
      default: begin
        HREADYOUT = 1'b1;
      end
    endcase
  end

  // State register.
  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_s;
    end
  end

  // ACCESS wait counter: cleared in SETUP, counts cycles with PREADY low.
  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      cnt_r <= '0;
    end else if (state_r == ST_SETUP) begin
      cnt_r <= '0;
    end else if ((state_r == ST_ACCESS) && !PREADY) begin
      cnt_r <= cnt_r + CNT_W'(1);
    end else begin
      cnt_r <= cnt_r;
    end
  end

  // Address and direction captured at acceptance. Acceptance only happens
  // once any previous ACCESS has completed, so the APB side stays stable.
  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      PADDR  <= 32'h0000_0000;
      PWRITE <= 1'b0;
    end else if (accept_s) begin
      PADDR  <= HADDR;
      PWRITE <= HWRITE;
    end else begin
      PADDR  <= PADDR;
      PWRITE <= PWRITE;
    end
  end

  // Write data captured at the end of the AHB data phase (WLATCH).
  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      PWDATA <= 32'h0000_0000;
    end else if (state_r == ST_WLATCH) begin
      PWDATA <= HWDATA;
    end else begin
      PWDATA <= PWDATA;
    end
  end

endmodule

// File: tb/tb_ahb_apb_bridge.sv
// Directed bench for ahb_apb_bridge (TIMEOUT=4): reads, writes, wait
// states, slave error, timeout, back-to-back and mid-transfer reset.
module tb_ahb_apb_bridge;

  logic        HCLK = 1'b0;
  logic        HRESETn;
  logic        HSEL;
  logic [31:0] HADDR;
  logic [1:0]  HTRANS;
  logic        HWRITE;
  logic [2:0]  HSIZE;
  logic [31:0] HWDATA;
  logic        HREADY;
  logic        HREADYOUT;
  logic        HRESP;
  logic [31:0] HRDATA;
  logic [31:0] PADDR;
  logic        PSEL;
  logic        PENABLE;
  logic        PWRITE;
  logic [31:0] PWDATA;
  logic [31:0] PRDATA;
  logic        PREADY;
  logic        PSLVERR;

  int n_cmp = 0;
  int n_bad = 0;

  ahb_apb_bridge #(.TIMEOUT(4)) dut (
    .HCLK(HCLK), .HRESETn(HRESETn), .HSEL(HSEL), .HADDR(HADDR),
    .HTRANS(HTRANS), .HWRITE(HWRITE), .HSIZE(HSIZE), .HWDATA(HWDATA),
    .HREADY(HREADY), .HREADYOUT(HREADYOUT), .HRESP(HRESP), .HRDATA(HRDATA),
    .PADDR(PADDR), .PSEL(PSEL), .PENABLE(PENABLE), .PWRITE(PWRITE),
    .PWDATA(PWDATA), .PRDATA(PRDATA), .PREADY(PREADY), .PSLVERR(PSLVERR)
  );

  always #5 HCLK = ~HCLK;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, obs, exp, $time);
    end
  endtask

  // Move to just after the next rising edge.
  task automatic adv();
    @(posedge HCLK);
    #1;
  endtask

  task automatic req(input logic [31:0] addr, input logic wr);
    HSEL   = 1'b1;
    HTRANS = 2'b10;
    HADDR  = addr;
    HWRITE = wr;
  endtask

  task automatic no_req();
    HSEL   = 1'b0;
    HTRANS = 2'b00;
  endtask

  // Expected strobes/response for one cycle, sampled at the falling edge.
  task automatic expect_cyc(input string tag, input logic psel, input logic pen,
                            input logic rdy, input logic resp);
    @(negedge HCLK);
    check_eq({tag, ".PSEL"},      {31'd0, PSEL},      {31'd0, psel});
    check_eq({tag, ".PENABLE"},   {31'd0, PENABLE},   {31'd0, pen});
    check_eq({tag, ".HREADYOUT"}, {31'd0, HREADYOUT}, {31'd0, rdy});
    check_eq({tag, ".HRESP"},     {31'd0, HRESP},     {31'd0, resp});
  endtask

  initial begin
    HRESETn = 1'b0;
    HSEL = 1'b0; HADDR = 32'h0; HTRANS = 2'b00; HWRITE = 1'b0;
    HSIZE = 3'b010; HWDATA = 32'h0; HREADY = 1'b1;
    PRDATA = 32'h0; PREADY = 1'b0; PSLVERR = 1'b0;
    repeat (2) @(posedge HCLK);
    #1;
    // Reset state
    check_eq("rst.HREADYOUT", {31'd0, HREADYOUT}, 32'd1);
    check_eq("rst.HRESP",     {31'd0, HRESP},     32'd0);
    check_eq("rst.PSEL",      {31'd0, PSEL},      32'd0);
    check_eq("rst.PADDR",     PADDR,              32'h0);
    check_eq("rst.HRDATA",    HRDATA,             32'h0);
    HRESETn = 1'b1;
    adv();

    // Single read, zero-wait
    req(32'h5000_0010, 1'b0);
    expect_cyc("rd.idle", 1'b0, 1'b0, 1'b1, 1'b0);
    adv(); no_req();
    expect_cyc("rd.setup", 1'b1, 1'b0, 1'b0, 1'b0);
    check_eq("rd.setup.PADDR", PADDR, 32'h5000_0010);
    check_eq("rd.setup.PWRITE", {31'd0, PWRITE}, 32'd0);
    adv(); PREADY = 1'b1; PRDATA = 32'hCAFE_0001;
    expect_cyc("rd.access", 1'b1, 1'b1, 1'b1, 1'b0);
    check_eq("rd.access.HRDATA", HRDATA, 32'hCAFE_0001);
    adv(); PREADY = 1'b0;
    expect_cyc("rd.after", 1'b0, 1'b0, 1'b1, 1'b0);
    check_eq("rd.after.HRDATA", HRDATA, 32'h0);
    check_eq("rd.after.PADDR", PADDR, 32'h5000_0010);

    // Idle/busy transfers and deselected slave get OKAY, no APB activity
    HSEL = 1'b1; HTRANS = 2'b01; HADDR = 32'h5000_0080;
    adv();
    expect_cyc("busy", 1'b0, 1'b0, 1'b1, 1'b0);
    HSEL = 1'b0; HTRANS = 2'b10;
    adv();
    expect_cyc("nosel", 1'b0, 1'b0, 1'b1, 1'b0);
    adv();

    // Single write
    req(32'h5000_0004, 1'b1);
    adv(); no_req(); HWDATA = 32'h1234_5678;
    expect_cyc("wr.wlatch", 1'b0, 1'b0, 1'b0, 1'b0);
    adv(); HWDATA = 32'hDEAD_DEAD;
    expect_cyc("wr.setup", 1'b1, 1'b0, 1'b0, 1'b0);
    check_eq("wr.setup.PWDATA", PWDATA, 32'h1234_5678);
    check_eq("wr.setup.PWRITE", {31'd0, PWRITE}, 32'd1);
    check_eq("wr.setup.PADDR", PADDR, 32'h5000_0004);
    adv(); PREADY = 1'b1; PRDATA = 32'h5555_AAAA;
    expect_cyc("wr.access", 1'b1, 1'b1, 1'b1, 1'b0);
    check_eq("wr.access.HRDATA", HRDATA, 32'h0);
    check_eq("wr.access.PWDATA", PWDATA, 32'h1234_5678);
    adv(); PREADY = 1'b0;
    expect_cyc("wr.after", 1'b0, 1'b0, 1'b1, 1'b0);
    check_eq("wr.after.PWDATA", PWDATA, 32'h1234_5678);

    // Read with three wait states
    req(32'h5000_0020, 1'b0);
    adv(); no_req();
    expect_cyc("ws.setup", 1'b1, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) begin
      adv();
      expect_cyc($sformatf("ws.wait%0d", i), 1'b1, 1'b1, 1'b0, 1'b0);
      check_eq($sformatf("ws.wait%0d.PADDR", i), PADDR, 32'h5000_0020);
    end
    adv(); PREADY = 1'b1; PRDATA = 32'h0BAD_F00D;
    expect_cyc("ws.done", 1'b1, 1'b1, 1'b1, 1'b0);
    check_eq("ws.done.HRDATA", HRDATA, 32'h0BAD_F00D);
    check_eq("ws.done.PADDR", PADDR, 32'h5000_0020);
    adv(); PREADY = 1'b0;
    expect_cyc("ws.after", 1'b0, 1'b0, 1'b1, 1'b0);

    // Slave error
    req(32'h5000_0030, 1'b0);
    adv(); no_req();
    adv(); PREADY = 1'b1; PSLVERR = 1'b1; PRDATA = 32'h7777_7777;
    expect_cyc("err.access", 1'b1, 1'b1, 1'b0, 1'b0);
    check_eq("err.access.HRDATA", HRDATA, 32'h0);
    adv(); PREADY = 1'b0; PSLVERR = 1'b0;
    expect_cyc("err.err1", 1'b0, 1'b0, 1'b0, 1'b1);
    adv();
    expect_cyc("err.err2", 1'b0, 1'b0, 1'b1, 1'b1);
    adv();
    expect_cyc("err.idle", 1'b0, 1'b0, 1'b1, 1'b0);

    // Timeout: PREADY stuck low, ACCESS lasts exactly TIMEOUT=4 cycles
    req(32'h5000_0040, 1'b0);
    adv(); no_req();
    expect_cyc("to.setup", 1'b1, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 4; i++) begin
      adv();
      expect_cyc($sformatf("to.access%0d", i), 1'b1, 1'b1, 1'b0, 1'b0);
    end
    adv();
    expect_cyc("to.err1", 1'b0, 1'b0, 1'b0, 1'b1);
    adv();
    expect_cyc("to.err2", 1'b0, 1'b0, 1'b1, 1'b1);
    adv();
    expect_cyc("to.idle", 1'b0, 1'b0, 1'b1, 1'b0);

    // Back-to-back reads: second accepted in the first's ACCESS cycle
    req(32'h5000_0100, 1'b0);
    adv(); HADDR = 32'h5000_0200;
    expect_cyc("b2b.setupA", 1'b1, 1'b0, 1'b0, 1'b0);
    check_eq("b2b.setupA.PADDR", PADDR, 32'h5000_0100);
    adv(); PREADY = 1'b1; PRDATA = 32'h1111_1111;
    expect_cyc("b2b.accessA", 1'b1, 1'b1, 1'b1, 1'b0);
    check_eq("b2b.accessA.HRDATA", HRDATA, 32'h1111_1111);
    check_eq("b2b.accessA.PADDR", PADDR, 32'h5000_0100);
    adv(); no_req(); PREADY = 1'b0;
    expect_cyc("b2b.setupB", 1'b1, 1'b0, 1'b0, 1'b0);
    check_eq("b2b.setupB.PADDR", PADDR, 32'h5000_0200);
    adv(); PREADY = 1'b1; PRDATA = 32'h2222_2222;
    expect_cyc("b2b.accessB", 1'b1, 1'b1, 1'b1, 1'b0);
    check_eq("b2b.accessB.HRDATA", HRDATA, 32'h2222_2222);
    adv(); PREADY = 1'b0;
    expect_cyc("b2b.idle", 1'b0, 1'b0, 1'b1, 1'b0);

    // Reset in the middle of an ACCESS abandons it at once
    req(32'h5000_0300, 1'b0);
    adv(); no_req();
    adv();
    expect_cyc("mrst.access", 1'b1, 1'b1, 1'b0, 1'b0);
    #1 HRESETn = 1'b0;
    #1;
    check_eq("mrst.PSEL",      {31'd0, PSEL},      32'd0);
    check_eq("mrst.PENABLE",   {31'd0, PENABLE},   32'd0);
    check_eq("mrst.HREADYOUT", {31'd0, HREADYOUT}, 32'd1);
    check_eq("mrst.PADDR",     PADDR,              32'h0);
    check_eq("mrst.PWDATA",    PWDATA,             32'h0);
    adv(); HRESETn = 1'b1;
    adv();
    expect_cyc("mrst.idle", 1'b0, 1'b0, 1'b1, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/ahb_apb_bridge.md
AHB_APB_BRIDGE -- requirements
Module: ahb_apb_bridge

Interface
REQ-001 Parameter TIMEOUT, default 255, is the maximum number of APB ACCESS cycles; 0 disables the timeout.
REQ-002 Reset is HRESETn, asynchronous, active-low; the clock is HCLK.
REQ-003 Port list (name, direction, width, meaning):
- HCLK  in  1  clock
- HRESETn  in  1  async active-low reset
- HSEL  in  1  slave select from the AHB decoder
- HADDR  in  32  address-phase address
- HTRANS  in  2  transfer type; bit1=1 means NONSEQ/SEQ
- HWRITE  in  1  1=write
- HSIZE  in  3  ignored; all transfers are 32-bit words
- HWDATA  in  32  write data, valid in the data phase
- HREADY  in  1  global ready from the interconnect mux
- HREADYOUT  out  1  slave ready to the mux
- HRESP  out  1  0=OKAY, 1=ERROR
- HRDATA  out  32  read data
- PADDR  out  32  APB address
- PSEL  out  1  APB select
- PENABLE  out  1  APB enable
- PWRITE  out  1  APB direction
- PWDATA  out  32  APB write data
- PRDATA  in  32  APB read data
- PREADY  in  1  APB ready
- PSLVERR  in  1  APB error

Function
REQ-004 A transfer is accepted in a cycle where HSEL=1, HREADY=1 and HTRANS[1]=1; at that edge HADDR and HWRITE are latched.
REQ-005 The FSM states are IDLE, WLATCH, SETUP, ACCESS, ERR1 and ERR2; acceptance is evaluated only in IDLE, ERR2, and ACCESS cycles that complete without error.
REQ-006 On acceptance:
- a read goes to SETUP;
- a write goes to WLATCH.
REQ-007 WLATCH lasts one cycle: HREADYOUT=0 and PSEL=0; HWDATA is captured into PWDATA at the end of the cycle; the next state is SETUP.
REQ-008 SETUP lasts one cycle: PSEL=1, PENABLE=0, PADDR and PWRITE come from the latched values, HREADYOUT=0; the next state is ACCESS and the timeout counter clears.
REQ-009 ACCESS outputs: PSEL=1 and PENABLE=1; PADDR, PWRITE and PWDATA hold stable.
REQ-010 ACCESS exits and completion:
- PREADY=1 and PSLVERR=0: HREADYOUT=1 and HRESP=0 in that same cycle; HRDATA=PRDATA combinationally for reads.
- Next state after an error-free completion: SETUP or WLATCH if a new transfer is accepted in that cycle (back-to-back), otherwise IDLE.
- PREADY=1 and PSLVERR=1: HREADYOUT=0; the next state is ERR1.
- PREADY=0: HREADYOUT=0; the counter increments.
- TIMEOUT>0, counter==TIMEOUT-1 and PREADY=0: the next state is ERR1, so ACCESS lasts at most TIMEOUT cycles.
REQ-011 ERR1: PSEL=0, PENABLE=0, HREADYOUT=0, HRESP=1; the next state is ERR2.
REQ-012 ERR2: PSEL=0, HREADYOUT=1, HRESP=1; the next state is SETUP or WLATCH if a transfer is accepted, else IDLE.
REQ-013 IDLE: HREADYOUT=1, HRESP=0, PSEL=0, PENABLE=0.
- HTRANS IDLE or BUSY, or HSEL=0, gets a zero-wait OKAY response with no APB activity.
REQ-014 HRDATA is 0 in every cycle other than an error-free read completion in ACCESS.
REQ-015 PENABLE is never 1 while PSEL=0; PSEL never stays asserted after ERR1 is entered.
REQ-016 Outside SETUP, ACCESS and WLATCH, PADDR, PWRITE and PWDATA hold their last value.

Reset
REQ-017 Asynchronous assertion forces, regardless of the cycle:
- state IDLE;
- PSEL, PENABLE, PWRITE and HRESP to 0;
- HREADYOUT to 1;
- PADDR, PWDATA, HRDATA and the counter to 0.
REQ-018 Reset asserted mid-transfer abandons the APB access immediately; the first cycle after deassertion is IDLE.

Verification
REQ-019 Read from 0x5000_0010 with PRDATA=0xCAFE_0001 and PREADY=1 at the first ACCESS cycle:
- SETUP at T+1, ACCESS at T+2;
- HREADYOUT=1 and HRDATA=0xCAFE_0001 at T+2.
REQ-020 Write of 0x1234_5678 to 0x5000_0004 with PREADY=1:
- WLATCH, then SETUP with PWDATA=0x1234_5678 and PWRITE=1, then ACCESS;
- HREADYOUT=1 in the ACCESS cycle.
REQ-021 PREADY held low for 3 ACCESS cycles, then high: exactly 4 ACCESS cycles, HREADYOUT=0 for the first 3, PADDR stable throughout.
REQ-022 PSLVERR=1 with PREADY=1:
- next cycle ERR1 (HREADYOUT=0, HRESP=1, PSEL=0);
- then ERR2 (HREADYOUT=1, HRESP=1);
- then IDLE.
REQ-023 TIMEOUT=4, PREADY stuck at 0: 4 ACCESS cycles, then ERR1 and ERR2 with HRESP=1.
REQ-024 Two reads issued back-to-back with PREADY=1: the second address is accepted in the first ACCESS cycle, SETUP follows directly, and no IDLE cycle occurs.
